// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential multiplier controller: operation
// encodings, FSM states, latency range limits, request payload and the
// signed high-word correction helper.
package mult_seq_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned HALF         = 16;
    localparam int unsigned CELL_LAT_MIN = 1;
    localparam int unsigned CELL_LAT_MAX = 4;
    localparam int unsigned LAT_CNT_W    = 3;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        RESP   = 3'd5
    } state_e;

    typedef struct packed {
        op_e             op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mul_req_t;

    // Amount to subtract from the unsigned high word to obtain the signed one.
    function automatic logic [XLEN-1:0] sign_corr(input op_e op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [XLEN-1:0] corr;
        corr = '0;
        if ((op == OP_MULXSU || op == OP_MULXSS) && a[XLEN-1]) begin
            corr = b;
        end
        if (op == OP_MULXSS && b[XLEN-1]) begin
            corr = corr + a;
        end
        return corr;
    endfunction

endpackage

// File: rtl/mult_seq_lat_cnt.sv
// Cell latency counter shared by both WAIT states.
//   clk, reset_n : clock, async active-low reset
//   load         : high during an ISSUE cycle; arms the counter with CELL_LAT
//   done_c       : combinational, high in the last cycle of the wait window
module mult_seq_lat_cnt
    import mult_seq_pkg::*;
#(
    parameter int unsigned CELL_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic done_c
);

    logic [LAT_CNT_W-1:0] cnt_q;

    // Down-counter: loaded in ISSUE, reaches 1 in the CELL_LAT-th WAIT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LAT_CNT_W'(CELL_LAT);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller driving an external 3-partial-product 16x16 multiplier
// cell to form 32x32 products (low word, or high word for unsigned/mixed/signed).
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   req_valid/req_ready          : request handshake; req_op, req_a, req_b payload
//   cell_src1/cell_src2/cell_en  : operands and load strobe to the cell
//   cell_p1/cell_p2/cell_p3      : lo*lo, src1lo*src2hi, src1hi*src2lo from the cell
//   rsp_valid/rsp_ready/rsp_data : result handshake
//   busy                         : controller not idle
// Build option: define MULT_SEQ_HIGH_EN to enable the high-word ops (1..3);
// without it every op returns the low word and req_op is ignored.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned CELL_LAT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic [XLEN-1:0] cell_src1,
    output logic [XLEN-1:0] cell_src2,
    output logic            cell_en,
    input  logic [XLEN-1:0] cell_p1,
    input  logic [XLEN-1:0] cell_p2,
    input  logic [XLEN-1:0] cell_p3,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    input  logic            rsp_ready,
    output logic            busy
);

    if (CELL_LAT < CELL_LAT_MIN || CELL_LAT > CELL_LAT_MAX) begin : g_bad_lat
        $error("mult_seq_ctrl: CELL_LAT out of range 1..4");
    end

    state_e          state_q, state_d;
    logic            req_ready_d, busy_d, cell_en_d, rsp_valid_d;
    logic [XLEN-1:0] cell_src1_d, cell_src2_d, rsp_data_d;
    logic            lat_done_c;

    // The cell strobe is high exactly in the ISSUE cycles, so it arms the counter.
    mult_seq_lat_cnt #(.CELL_LAT(CELL_LAT)) u_lat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cell_en),
        .done_c  (lat_done_c)
    );

`ifdef MULT_SEQ_HIGH_EN
    mul_req_t        req_q, req_d;
    logic [XLEN-1:0] lo_hi_q, lo_hi_d;
    logic [XLEN-1:0] hh_q, hh_d;
    logic            fin_q, fin_d;
    logic [63:0]     lo64_c;

    // Low 64 bits of a*b without the ahi*bhi term (at most 50 bits wide).
    assign lo64_c = 64'(cell_p1) + ((64'(cell_p2) + 64'(cell_p3)) << HALF);
`else
    logic [XLEN-1:0] lo32_c;
    logic            unused_op;

    assign lo32_c    = cell_p1 + ((cell_p2 + cell_p3) << HALF);
    assign unused_op = ^req_op;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cell_en_d   = 1'b0;
        cell_src1_d = cell_src1;
        cell_src2_d = cell_src2;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
`ifdef MULT_SEQ_HIGH_EN
        req_d       = req_q;
        lo_hi_d     = lo_hi_q;
        hh_d        = hh_q;
        fin_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = ISSUE1;
                    cell_en_d   = 1'b1;
                    cell_src1_d = req_a;
                    cell_src2_d = req_b;
`ifdef MULT_SEQ_HIGH_EN
                    req_d       = '{op: op_e'(req_op), a: req_a, b: req_b};
`endif
                end
            end
            ISSUE1: state_d = WAIT1;
            WAIT1: begin
                if (lat_done_c) begin
`ifdef MULT_SEQ_HIGH_EN
                    if (req_q.op == OP_MUL) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = lo64_c[XLEN-1:0];
                    end else begin
                        state_d     = ISSUE2;
                        cell_en_d   = 1'b1;
                        cell_src1_d = {16'h0, req_q.a[XLEN-1:HALF]};
                        cell_src2_d = {16'h0, req_q.b[XLEN-1:HALF]};
                        lo_hi_d     = lo64_c[63:XLEN];
                    end
`else
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = lo32_c;
`endif
                end
            end
`ifdef MULT_SEQ_HIGH_EN
            ISSUE2: state_d = WAIT2;
            // Capture ahi*bhi, then combine in a separate cycle to keep the
            // three-operand add/correct off the cell output path.
            WAIT2: begin
                if (fin_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = lo_hi_q + hh_q - sign_corr(req_q.op, req_q.a, req_q.b);
                end else if (lat_done_c) begin
                    hh_d  = cell_p1;
                    fin_d = 1'b1;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cell_en   <= 1'b0;
            cell_src1 <= '0;
            cell_src2 <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef MULT_SEQ_HIGH_EN
            req_q     <= '0;
            lo_hi_q   <= '0;
            hh_q      <= '0;
            fin_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
            cell_en   <= cell_en_d;
            cell_src1 <= cell_src1_d;
            cell_src2 <= cell_src2_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
`ifdef MULT_SEQ_HIGH_EN
            req_q     <= req_d;
            lo_hi_q   <= lo_hi_d;
            hh_q      <= hh_d;
            fin_q     <= fin_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: models the external multiplier cell,
// compares results against plain 64-bit arithmetic, and checks latency, cell
// strobe count, response hold behaviour and asynchronous reset.
module tb_mult_seq_ctrl;

    localparam int unsigned CELL_LAT = 1;
`ifdef MULT_SEQ_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    mult_seq_ctrl #(.CELL_LAT(CELL_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier cell: operands latched on cell_en, products CELL_LAT cycles later.
    logic [31:0] s1_pipe [CELL_LAT];
    logic [31:0] s2_pipe [CELL_LAT];

    always @(posedge clk) begin
        if (cell_en) begin
            s1_pipe[0] <= cell_src1;
            s2_pipe[0] <= cell_src2;
        end
        for (int i = 1; i < int'(CELL_LAT); i++) begin
            s1_pipe[i] <= s1_pipe[i-1];
            s2_pipe[i] <= s2_pipe[i-1];
        end
    end

    always_comb begin
        cell_p1 = {16'h0, s1_pipe[CELL_LAT-1][15:0]}  * {16'h0, s2_pipe[CELL_LAT-1][15:0]};
        cell_p2 = {16'h0, s1_pipe[CELL_LAT-1][15:0]}  * {16'h0, s2_pipe[CELL_LAT-1][31:16]};
        cell_p3 = {16'h0, s1_pipe[CELL_LAT-1][31:16]} * {16'h0, s2_pipe[CELL_LAT-1][15:0]};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result from full 64-bit products.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, prod;
        ua = $signed({32'h0, a});
        ub = $signed({32'h0, b});
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (!HIGH_EN || op == 2'd0) begin
            prod = ua * ub;
            return prod[31:0];
        end
        case (op)
            2'd1:    prod = ua * ub;
            2'd2:    prod = sa * ub;
            default: prod = sa * sb;
        endcase
        return prod[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return (HIGH_EN && op != 2'd0) ? 2 * int'(CELL_LAT) + 4 : int'(CELL_LAT) + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'h0001_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".rsp_data"},  rsp_data,       32'd0);
        check_eq({tag, ".cell_en"},   32'(cell_en),   32'd0);
        check_eq({tag, ".cell_src1"}, cell_src1,      32'd0);
        check_eq({tag, ".cell_src2"}, cell_src2,      32'd0);
        check_eq({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit noise);
        logic [31:0] exp;
        int          k;
        int          en_cnt;
        bit          seen;
        exp    = ref_mul(op, a, b);
        k      = 0;
        en_cnt = 0;
        seen   = 1'b0;
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (cell_en) en_cnt++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            check_eq("busy_wait", 32'(busy), 32'd1);
            check_eq("ready_wait", 32'(req_ready), 32'd0);
            // Requests while busy must be ignored.
            req_valid = noise & 1'($urandom);
            req_op    = 2'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
        end
        req_valid = 1'b0;
        if (!seen) begin
            check_eq("rsp_timeout", 32'(k), 32'(exp_lat(op)));
            return;
        end
        check_eq("latency", 32'(k), 32'(exp_lat(op)));
        check_eq("rsp_data", rsp_data, exp);
        check_eq("cell_en_cnt", 32'(en_cnt), (HIGH_EN && op != 2'd0) ? 32'd2 : 32'd1);
        for (int d = 0; d < hold; d++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_data", rsp_data, exp);
            check_eq("hold_ready", 32'(req_ready), 32'd0);
            check_eq("hold_cell_en", 32'(cell_en), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_ready", 32'(req_ready), 32'd1);
        check_eq("post_busy", 32'(busy), 32'd0);
    endtask

    // Abort an operation with reset in its final wait cycle.
    task automatic reset_mid_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c < exp_lat(op) - 1; c++) @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        check_reset_outputs("held_rst");
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        check_eq("ready_after_rst", 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Directed corner cases; the first accept lands on the first clock after reset.
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
        run_op(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        run_op(2'd0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
        run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
        run_op(2'd3, 32'h8000_0000, 32'h8000_0000, 5, 1'b1);
        run_op(2'd2, 32'h8000_0001, 32'hFFFF_FFFF, 5, 1'b0);

        reset_mid_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom), pick_operand(), pick_operand(),
                   int'($urandom_range(0, 5)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
